irq_aggregator: RTL

IRQ_AGGREGATOR -- requirements
Module: irq_aggregator

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_rr_arbiter.sv | 27 ++
 rtl/irq_aggregator.sv | 118 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared defaults, width helper and claim FSM encoding
// for the interrupt aggregator.
package irq_pkg;

    localparam int NUM_IRQ_DEF = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational round-robin pick: first requester above
// last_grant_i, wrapping; none_o when nothing requests.
module irq_rr_arbiter #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [ID_W-1:0]    id_o,
    output logic               none_o
);

    always_comb begin
        int idx;
        id_o   = '0;
        none_o = 1'b1;
        idx    = 0;
        for (int k = 1; k <= NUM_IRQ; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_IRQ;
            if (none_o && req_i[idx]) begin
                id_o   = ID_W'(idx);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: edge/level pending capture, masking,
// round-robin claim with one-cycle grant, and completion.
module irq_aggregator
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] enable,
    input  logic               claim_req,
    output logic               claim_ack,
    output logic [ID_W-1:0]    claim_id,
    output logic               claim_none,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
    output logic               irq_out
);

    state_e             state_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] svc_q, svc_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic               irq_q;
    logic               ack_q;
    logic [ID_W-1:0]    id_q;
    logic               none_q;

    logic [NUM_IRQ-1:0] edge_w;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] grant_oh;
    logic [NUM_IRQ-1:0] done_oh;
    logic [ID_W-1:0]    arb_id;
    logic               arb_none;
    logic               grant;

    assign edge_w   = irq_in & ~prev_q;
    assign pending  = (edge_mode & pend_q) | (~edge_mode & irq_in);
    assign eligible = pending & enable & ~svc_q;
    assign grant    = (state_q == IDLE) && claim_req && !arb_none;

    irq_rr_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (eligible),
        .last_grant_i (last_q),
        .id_o         (arb_id),
        .none_o       (arb_none)
    );

    // A fresh edge on the granted source survives the grant clear.
    always_comb begin
        grant_oh = '0;
        done_oh  = '0;
        if (grant) begin
            grant_oh[arb_id] = 1'b1;
        end
        if (complete_valid && (int'(complete_id) < NUM_IRQ)) begin
            done_oh[complete_id] = 1'b1;
        end
        pend_d = (pend_q & ~grant_oh) | (edge_w & edge_mode);
        svc_d  = (svc_q & ~done_oh) | grant_oh;
        last_d = grant ? arb_id : last_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
            svc_q  <= '0;
            last_q <= ID_W'(NUM_IRQ - 1);
            irq_q  <= 1'b0;
        end else begin
            prev_q <= irq_in;
            pend_q <= pend_d;
            svc_q  <= svc_d;
            last_q <= last_d;
            irq_q  <= |eligible;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            id_q    <= '0;
            none_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            id_q   <= '0;
            none_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (claim_req) begin
                        state_q <= GRANT;
                        ack_q   <= 1'b1;
                        id_q    <= arb_id;
                        none_q  <= arb_none;
                    end
                end
                GRANT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign claim_ack  = ack_q;
    assign claim_id   = id_q;
    assign claim_none = none_q;
    assign irq_out    = irq_q;

endmodule
